// File: rtl/clk_div_meter.sv
// Divided-clock meter: recovers the half-period of sig_in in in_clk cycles,
// flags when consecutive captures agree (locked) and when edges stop (timeout).
//
// Ports:
//   in_clk     measurement clock, rising edge
//   rst_n      asynchronous active-low reset
//   sig_in     divided clock under measurement (asynchronous)
//   clr        synchronous clear of measurement state (not the synchronizer)
//   B_n_meas   last captured half-period
//   meas_valid one-cycle pulse when B_n_meas updates
//   locked     last LOCK_CNT captures identical
//   timeout    no edge seen for 2^CNT_BW-1 cycles
module clk_div_meter #(
    parameter int CNT_BW      = 13,
    parameter int LOCK_CNT    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              in_clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              clr,
    output logic [CNT_BW-1:0] B_n_meas,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);

    localparam logic [CNT_BW-1:0] MAX       = '1;
    localparam logic [CNT_BW-1:0] ONE       = CNT_BW'(1);
    localparam logic [3:0]        MATCH_TOP = 4'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOCK,
        TOUT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_seen;
    logic [CNT_BW-1:0]      cnt;
    logic [3:0]             match_cnt;
    logic [3:0]             match_next;
    logic                   capture;
    logic                   same;
    state_t                 state;

    // Synchronizer and history flop are untouched by clr, so an edge in
    // flight across a clr is still tracked correctly afterwards.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_seen  = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign capture    = edge_seen && (state == MEAS || state == LOCK);
    assign same       = (cnt == B_n_meas);
    assign match_next = (match_cnt == MATCH_TOP) ? MATCH_TOP
                                                 : match_cnt + 4'd1;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            match_cnt  <= '0;
            state      <= IDLE;
            B_n_meas   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            match_cnt  <= '0;
            state      <= IDLE;
            B_n_meas   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (edge_seen) begin
                cnt <= ONE;
            end else if (cnt != MAX) begin
                cnt <= cnt + ONE;
            end

            if (capture) begin
                B_n_meas   <= cnt;
                meas_valid <= 1'b1;
                if (same) begin
                    match_cnt <= match_next;
                    if (match_next == MATCH_TOP) begin
                        locked <= 1'b1;
                        state  <= LOCK;
                    end
                end else begin
                    match_cnt <= '0;
                    locked    <= 1'b0;
                    state     <= MEAS;
                end
            end else if (edge_seen) begin
                // First edge after IDLE/TOUT only re-arms: the interval
                // ending here has no valid start.
                state   <= MEAS;
                timeout <= 1'b0;
            end else if (cnt == MAX) begin
                state     <= TOUT;
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_meter.sv
// Randomized and directed bench for clk_div_meter with an
// interval-based behavioural model and per-cycle comparison.
module tb_clk_div_meter;

    localparam int BW    = 13;
    localparam int LOCKN = 2;
    localparam int SYNC  = 2;
    localparam int MAXV  = 8191;

    logic          in_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          sig_in = 1'b0;
    logic          clr    = 1'b0;
    logic [BW-1:0] B_n_meas;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    clk_div_meter #(
        .CNT_BW      (BW),
        .LOCK_CNT    (LOCKN),
        .SYNC_STAGES (SYNC)
    ) dut (
        .in_clk     (in_clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .clr        (clr),
        .B_n_meas   (B_n_meas),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Behavioural model: sampled input history, cycles since last edge,
    // whether an interval start is known, and the run length of identical
    // captures ending at the current reported value.
    bit m_hist [1:SYNC+1];
    int m_since;
    int m_b;
    int m_run;
    bit m_armed;
    bit m_mv;
    bit m_lock;
    bit m_tout;
    bit m_e;

    task automatic model_clear();
        m_since = 0;
        m_b     = 0;
        m_run   = 1;
        m_armed = 1'b0;
        m_mv    = 1'b0;
        m_lock  = 1'b0;
        m_tout  = 1'b0;
    endtask

    always @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= SYNC + 1; i++) m_hist[i] = 1'b0;
            model_clear();
        end else begin
            // Input seen SYNC cycles ago differs from the one before it.
            m_e = (m_hist[SYNC] != m_hist[SYNC+1]);
            for (int i = SYNC + 1; i >= 2; i--) m_hist[i] = m_hist[i-1];
            m_hist[1] = sig_in;
            if (clr) begin
                model_clear();
            end else begin
                m_mv = 1'b0;
                if (m_e) begin
                    if (m_armed) begin
                        if (m_since == m_b) begin
                            if (m_run < LOCKN) m_run++;
                        end else begin
                            m_run = 1;
                        end
                        m_b    = m_since;
                        m_mv   = 1'b1;
                        m_lock = (m_run >= LOCKN);
                    end else begin
                        m_armed = 1'b1;
                        m_tout  = 1'b0;
                    end
                    m_since = 1;
                end else begin
                    if (m_since == MAXV) begin
                        m_tout  = 1'b1;
                        m_armed = 1'b0;
                        m_lock  = 1'b0;
                        m_run   = 1;
                    end
                    if (m_since < MAXV) m_since++;
                end
            end
        end
    end

    always @(negedge in_clk) begin
        if (running) begin
            check("B_n_meas",   int'(B_n_meas),   m_b);
            check("meas_valid", int'(meas_valid), int'(m_mv));
            check("locked",     int'(locked),     int'(m_lock));
            check("timeout",    int'(timeout),    int'(m_tout));
        end
    end

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic square(input int n, input int halves);
        repeat (halves) begin
            sig_in = ~sig_in;
            repeat (n) step();
        end
    endtask

    task automatic half_rand(input int n);
        sig_in = ~sig_in;
        repeat (n) begin
            clr = ($urandom_range(0, 59) == 0);
            step();
        end
        clr = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_B"},    int'(B_n_meas),   0);
        check({tag, "_mv"},   int'(meas_valid), 0);
        check({tag, "_lock"}, int'(locked),     0);
        check({tag, "_tout"}, int'(timeout),    0);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        running = 1'b1;
        outs_zero("reset");

        // N=10: locks on the second capture
        square(10, 6);
        check("n10_B", int'(B_n_meas), 10);
        check("n10_lock", int'(locked), 1);
        check("n10_tout", int'(timeout), 0);
        check("model_n10_B", m_b, 10);

        // N=1: edge every cycle
        square(1, 12);
        check("n1_mv", int'(meas_valid), 1);
        check("n1_B", int'(B_n_meas), 1);
        check("n1_lock", int'(locked), 1);

        // Period changes
        square(10, 4);
        square(11, 2);
        check("n11_first_B", int'(B_n_meas), 11);
        check("n11_first_lock", int'(locked), 0);
        square(11, 1);
        check("n11_relock", int'(locked), 1);
        square(100, 3);
        check("n100_lock", int'(locked), 1);
        square(101, 2);
        check("n101_first_B", int'(B_n_meas), 101);
        check("n101_first_lock", int'(locked), 0);
        square(101, 1);
        check("n101_relock", int'(locked), 1);
        square(6250, 2);
        check("n6250_first_B", int'(B_n_meas), 6250);
        check("n6250_first_lock", int'(locked), 0);
        square(6250, 1);
        check("n6250_relock", int'(locked), 1);

        // Edge exactly at cnt == MAX is a valid capture
        square(MAXV, 2);
        check("max_B", int'(B_n_meas), MAXV);
        check("max_tout", int'(timeout), 0);
        check("max_lock", int'(locked), 0);

        // Asymmetric 5/7
        repeat (6) begin
            square(5, 1);
            square(7, 1);
        end
        check("asym_B", int'(B_n_meas), 5);
        check("asym_lock", int'(locked), 0);

        // Timeout after reset with a constant input
        sig_in = 1'b0;
        rst_n = 1'b0;
        #1;
        outs_zero("rst_tout");
        step();
        step();
        rst_n = 1'b1;
        repeat (8195) step();
        check("tout_set", int'(timeout), 1);
        check("tout_B", int'(B_n_meas), 0);
        check("model_tout", int'(m_tout), 1);
        square(100, 1);
        check("tout_clear", int'(timeout), 0);
        check("tout_clear_mv0", int'(B_n_meas), 0);
        square(100, 3);
        check("tout_relock", int'(locked), 1);
        check("tout_relock_B", int'(B_n_meas), 100);

        // Asynchronous reset mid-interval while locked
        sig_in = ~sig_in;
        repeat (40) step();
        rst_n = 1'b0;
        #1;
        outs_zero("midrst");
        step();
        rst_n = 1'b1;
        repeat (60) step();
        square(100, 4);
        check("midrst_relock", int'(locked), 1);

        // Synchronous clear while locked
        sig_in = ~sig_in;
        repeat (40) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        outs_zero("clr");
        repeat (60) step();
        square(100, 4);
        check("clr_relock", int'(locked), 1);

        // Edge arriving in the clr cycle is ignored
        sig_in = ~sig_in;
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        outs_zero("clr_edge");
        repeat (97) step();
        square(100, 2);
        check("clr_edge_lock0", int'(locked), 0);
        square(100, 1);
        check("clr_edge_relock", int'(locked), 1);

        // Random periods, asymmetric halves and stray clr pulses
        for (int seg = 0; seg < 24; seg++) begin
            int n;
            int h;
            bit asym;
            n = $urandom_range(1, 30);
            h = $urandom_range(2, 6);
            asym = ($urandom_range(0, 3) == 0);
            repeat (h) begin
                if (asym) half_rand($urandom_range(1, 30));
                else half_rand(n);
            end
        end
        repeat (5) step();

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
